// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave frame engine.
package spi_pkg;

   typedef enum logic [1:0] {
      SPI_MODE0 = 2'd0,
      SPI_MODE1 = 2'd1,
      SPI_MODE2 = 2'd2,
      SPI_MODE3 = 2'd3
   } spi_mode_e;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam int FRAME_W_DEF     = 16;
   localparam int CH_BITS_DEF     = 4;
   localparam int SYNC_STAGES_DEF = 2;

   // Idle level of sclk for a mode.
   function automatic logic mode_cpol(spi_mode_e m);
      logic [1:0] b;
      b = m;
      return b[1];
   endfunction

   // Clock phase: 1 means data is sampled on the trailing edge.
   function automatic logic mode_cpha(spi_mode_e m);
      logic [1:0] b;
      b = m;
      return b[0];
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with rise/fall detect on the synchronised level.
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   // Next state of the synchroniser chain and the one-cycle-old level.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
      prev_d = sync_q[STAGES-1];
   end

   // Chain resets to the line's idle level so release of reset creates no edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign q    = sync_q[STAGES-1];
   assign rise = q & ~prev_q;
   assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_frame_slave.sv
// Oversampled SPI slave: receives MSB-first frames in any CPOL/CPHA mode,
// splits them into payload/channel, and shifts a host word out on MISO.
module spi_frame_slave import spi_pkg::*; #(
   parameter int FRAME_W     = FRAME_W_DEF,
   parameter int CH_BITS     = CH_BITS_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [1:0]                 spi_mode,
   input  logic                       cs_bar,
   input  logic                       sclk,
   input  logic                       mosi,
   output logic                       miso,
   input  logic [FRAME_W-1:0]         tx_data,
   input  logic                       tx_load,
   output logic                       tx_ready,
   output logic [FRAME_W-CH_BITS-1:0] rx_data,
   output logic [CH_BITS-1:0]         rx_ch,
   output logic                       rx_valid,
   input  logic                       rx_ready,
   output logic                       overrun,
   input  logic                       ovr_clr,
   output logic                       abort,
   output logic                       busy
);

   localparam int PAY_W = FRAME_W - CH_BITS;
   localparam int CNT_W = $clog2(FRAME_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

   logic sclk_s, sclk_rise, sclk_fall;
   logic cs_s, cs_rise, cs_fall;
   logic mosi_s;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
      .clk(clk), .rst_n(reset), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk(clk), .rst_n(reset), .d(cs_bar), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
   );

   // mosi only needs a level synchroniser, aligned in latency with sclk.
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

   always_comb mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) mosi_sync_q <= '0;
      else        mosi_sync_q <= mosi_sync_d;
   end

   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // Register state.
   state_e             state_q, state_d;
   spi_mode_e          mode_q, mode_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [FRAME_W-2:0] rx_sh_q, rx_sh_d;
   logic [FRAME_W-1:0] tx_sh_q, tx_sh_d;
   logic [FRAME_W-1:0] hold_q, hold_d;
   logic               tx_ready_q, tx_ready_d;
   logic [PAY_W-1:0]   rx_data_q, rx_data_d;
   logic [CH_BITS-1:0] rx_ch_q, rx_ch_d;
   logic               rx_valid_q, rx_valid_d;
   logic               overrun_q, overrun_d;
   logic               abort_q, abort_d;
   logic               miso_q, miso_d;

   logic               cpol, cpha, sclk_chg, lead_edge, trail_edge;
   logic               sample_edge, shift_edge, frame_done;
   logic [FRAME_W-1:0] frame_word;

   // Map synchronised sclk edges onto sample/shift events for the latched mode.
   always_comb begin
      cpol        = mode_cpol(mode_q);
      cpha        = mode_cpha(mode_q);
      sclk_chg    = sclk_rise | sclk_fall;
      lead_edge   = sclk_chg & (sclk_s != cpol);
      trail_edge  = sclk_chg & (sclk_s == cpol);
      sample_edge = cpha ? trail_edge : lead_edge;
      shift_edge  = cpha ? lead_edge  : trail_edge;
   end

   // Frame FSM, shift registers, output register and TX holding register.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      bit_cnt_d  = bit_cnt_q;
      rx_sh_d    = rx_sh_q;
      tx_sh_d    = tx_sh_q;
      hold_d     = hold_q;
      tx_ready_d = tx_ready_q;
      rx_data_d  = rx_data_q;
      rx_ch_d    = rx_ch_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = overrun_q & ~ovr_clr;
      abort_d    = 1'b0;
      frame_done = 1'b0;
      frame_word = {rx_sh_q, mosi_s};

      if (cs_s) mode_d = spi_mode_e'(spi_mode);
      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d    = SHIFT;
               bit_cnt_d  = '0;
               tx_sh_d    = tx_ready_q ? '0 : hold_q;
               tx_ready_d = 1'b1;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               state_d   = IDLE;
               abort_d   = (bit_cnt_q != '0);
               bit_cnt_d = '0;
            end else if (sample_edge) begin
               rx_sh_d = frame_word[FRAME_W-2:0];
               if (bit_cnt_q == LAST_BIT) begin
                  // Wrap and reload so the next frame can follow without a cs_bar toggle.
                  bit_cnt_d  = '0;
                  frame_done = 1'b1;
                  tx_sh_d    = tx_ready_q ? '0 : hold_q;
                  tx_ready_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else if (shift_edge && bit_cnt_q != '0) begin
               // The MSB is already on miso at frame start, so the shift edge
               // preceding the first sample of a frame is skipped.
               tx_sh_d = {tx_sh_q[FRAME_W-2:0], 1'b0};
            end
         end
         default: state_d = IDLE;
      endcase

      if (frame_done) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = frame_word[FRAME_W-1:CH_BITS];
            rx_ch_d    = frame_word[CH_BITS-1:0];
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end

      // Applied after the frame-start copy so a same-cycle load targets the next frame.
      if (tx_load && tx_ready_q) begin
         hold_d     = tx_data;
         tx_ready_d = 1'b0;
      end

      miso_d = (state_d == SHIFT) ? tx_sh_d[FRAME_W-1] : 1'b0;
   end

   // State registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         mode_q     <= SPI_MODE0;
         bit_cnt_q  <= '0;
         rx_sh_q    <= '0;
         tx_sh_q    <= '0;
         hold_q     <= '0;
         tx_ready_q <= 1'b1;
         rx_data_q  <= '0;
         rx_ch_q    <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         abort_q    <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_sh_q    <= rx_sh_d;
         tx_sh_q    <= tx_sh_d;
         hold_q     <= hold_d;
         tx_ready_q <= tx_ready_d;
         rx_data_q  <= rx_data_d;
         rx_ch_q    <= rx_ch_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
         abort_q    <= abort_d;
         miso_q     <= miso_d;
      end
   end

   assign miso     = miso_q;
   assign tx_ready = tx_ready_q;
   assign rx_data  = rx_data_q;
   assign rx_ch    = rx_ch_q;
   assign rx_valid = rx_valid_q;
   assign overrun  = overrun_q;
   assign abort    = abort_q;
   assign busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: bus-level SPI master tasks drive frames,
// expected frames go into a scoreboard queue, a monitor checks each handshake.
module tb_spi_frame_slave;

   localparam int H = 8;   // sclk half-period in clk cycles

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  spi_mode;
   logic        cs_bar, sclk, mosi, miso;
   logic [15:0] tx_data;
   logic        tx_load, tx_ready;
   logic [11:0] rx_data;
   logic [3:0]  rx_ch;
   logic        rx_valid, rx_ready, overrun, ovr_clr, abort, busy;

   int checks = 0;
   int errors = 0;
   int abort_cnt = 0;
   int rx_cnt = 0;

   typedef struct {
      logic [11:0] data;
      logic [3:0]  ch;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   spi_frame_slave #(.FRAME_W(16), .CH_BITS(4), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .spi_mode(spi_mode), .cs_bar(cs_bar), .sclk(sclk),
      .mosi(mosi), .miso(miso), .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_ch(rx_ch), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .overrun(overrun), .ovr_clr(ovr_clr), .abort(abort), .busy(busy)
   );

   // Monitor: counts abort pulses and checks every accepted output word.
   always @(negedge clk) begin
      if (abort === 1'b1) abort_cnt++;
      if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
         checks++;
         rx_cnt++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected: got ch=%h data=%h, required no output", rx_ch, rx_data);
         end else begin
            mon_e = sb.pop_front();
            if (rx_ch !== mon_e.ch || rx_data !== mon_e.data) begin
               errors++;
               $display("FAIL rx_frame: got ch=%h data=%h, required ch=%h data=%h",
                        rx_ch, rx_data, mon_e.ch, mon_e.data);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push_exp(input logic [15:0] f);
      exp_t e;
      e.data = f[15:4];
      e.ch   = f[3:0];
      sb.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_miso"},     32'(miso),     32'd0);
      chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
      chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
      chk({tag, "_rx_data"},  32'(rx_data),  32'd0);
      chk({tag, "_rx_ch"},    32'(rx_ch),    32'd0);
      chk({tag, "_overrun"},  32'(overrun),  32'd0);
      chk({tag, "_abort"},    32'(abort),    32'd0);
      chk({tag, "_busy"},     32'(busy),     32'd0);
   endtask

   task automatic set_mode(input logic [1:0] m);
      spi_mode = m;
      sclk     = m[1];
      tick(10);
   endtask

   task automatic load_tx(input logic [15:0] w);
      tx_data = w;
      tx_load = 1'b1;
      tick(1);
      tx_load = 1'b0;
      tick(1);
   endtask

   task automatic cs_low();
      cs_bar = 1'b0;
      tick(H);
   endtask

   task automatic cs_high();
      cs_bar = 1'b1;
      tick(12);
   endtask

   // Master side of one frame (or nbits of it); returns MISO as sampled by the master.
   task automatic xfer(input logic [15:0] d, input int nbits, output logic [15:0] so);
      logic cpol, cpha;
      cpol = spi_mode[1];
      cpha = spi_mode[0];
      so = '0;
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            mosi = d[15-i];
            tick(H);
            sclk = ~cpol;
            so[15-i] = miso;
            tick(H);
            sclk = cpol;
         end else begin
            sclk = ~cpol;
            mosi = d[15-i];
            tick(H);
            sclk = cpol;
            so[15-i] = miso;
            tick(H);
         end
      end
      if (!cpha) tick(H);
   endtask

   initial begin
      logic [15:0] so;
      logic [15:0] txw [4];
      int r0;

      txw[0] = 16'hF1F1; txw[1] = 16'hA55A; txw[2] = 16'h8001; txw[3] = 16'h1234;
      reset = 1'b0; spi_mode = 2'd0; cs_bar = 1'b1; sclk = 1'b0; mosi = 1'b0;
      tx_data = '0; tx_load = 1'b0; rx_ready = 1'b1; ovr_clr = 1'b0;
      tick(5);
      check_reset_outputs("rst");
      reset = 1'b1;
      tick(5);

      // Mode 0 with a loaded TX word.
      set_mode(2'd0);
      load_tx(16'hF1F1);
      chk("tx_ready_after_load", 32'(tx_ready), 32'd0);
      push_exp(16'hABC3);
      cs_low();
      chk("busy_in_frame", 32'(busy), 32'd1);
      chk("tx_ready_after_start", 32'(tx_ready), 32'd1);
      xfer(16'hABC3, 16, so);
      chk("miso_mode0", 32'(so), 32'hF1F1);
      cs_high();
      chk("busy_after_frame", 32'(busy), 32'd0);
      chk("miso_deselected", 32'(miso), 32'd0);

      // Modes 1..3, same MOSI frame, distinct TX words.
      for (int m = 1; m < 4; m++) begin
         set_mode(2'(m));
         load_tx(txw[m]);
         push_exp(16'h5A5A);
         cs_low();
         xfer(16'h5A5A, 16, so);
         chk($sformatf("miso_mode%0d", m), 32'(so), 32'(txw[m]));
         cs_high();
      end

      // 16 back-to-back frames with cs_bar held low.
      set_mode(2'd0);
      r0 = rx_cnt;
      cs_low();
      for (int i = 0; i < 16; i++) begin
         push_exp(16'(i));
         xfer(16'(i), 16, so);
      end
      cs_high();
      chk("b2b_count", 32'(rx_cnt - r0), 32'd16);
      chk("b2b_overrun", 32'(overrun), 32'd0);
      chk("b2b_miso_zero", 32'(so), 32'd0);

      // Consumer stalled: second frame dropped, overrun set then cleared.
      rx_ready = 1'b0;
      push_exp(16'h7770);
      cs_low();
      xfer(16'h7770, 16, so);
      xfer(16'h1115, 16, so);
      cs_high();
      chk("ovr_set", 32'(overrun), 32'd1);
      chk("ovr_held_valid", 32'(rx_valid), 32'd1);
      chk("ovr_held_ch", 32'(rx_ch), 32'd0);
      chk("ovr_held_data", 32'(rx_data), 32'h777);
      ovr_clr = 1'b1;
      tick(1);
      ovr_clr = 1'b0;
      tick(1);
      chk("ovr_cleared", 32'(overrun), 32'd0);
      rx_ready = 1'b1;
      tick(3);
      chk("ovr_drained", 32'(rx_valid), 32'd0);

      // Truncated frame after 7 bits, then a full frame.
      r0 = abort_cnt;
      cs_low();
      xfer(16'hFFFF, 7, so);
      cs_high();
      chk("abort_pulse", 32'(abort_cnt - r0), 32'd1);
      chk("abort_no_valid", 32'(rx_valid), 32'd0);
      push_exp(16'h1234);
      cs_low();
      xfer(16'h1234, 16, so);
      cs_high();

      // Reset in the middle of a frame (after 9 bits).
      r0 = abort_cnt;
      cs_low();
      xfer(16'hFFFF, 9, so);
      reset = 1'b0;
      tick(2);
      check_reset_outputs("midrst");
      cs_bar = 1'b1;
      sclk = 1'b0;
      tick(3);
      reset = 1'b1;
      tick(10);
      chk("midrst_no_abort", 32'(abort_cnt - r0), 32'd0);
      push_exp(16'h0001);
      cs_low();
      xfer(16'h0001, 16, so);
      cs_high();

      tick(20);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      chk("abort_total", 32'(abort_cnt), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_frame_slave.md
# spi_frame_slave

Parametrised SPI slave frame engine for the UART/SPI bridge. It oversamples an external SPI bus in the system clock domain and receives MSB-first frames of configurable width in any of the four CPOL/CPHA modes. Each received frame is split into a channel ID and a payload and delivered through a valid/ready output register. A host-loaded word is shifted out on MISO during the same frame.

## Interface
Parameters:
- FRAME_W, 16, bits per SPI frame; FRAME_W > CH_BITS.
- CH_BITS, 4, channel ID width (frame LSBs); ≥ 1.
- SYNC_STAGES, 2, synchroniser depth for sclk/cs_bar/mosi; ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- spi_mode  in  2  {CPOL,CPHA}; latched only while the synchronised cs_bar is high.
- cs_bar  in  1  SPI chip select, active low.
- sclk  in  1  SPI clock.
- mosi  in  1  SPI data in.
- miso  out  1  SPI data out; 0 while deselected.
- tx_data  in  FRAME_W  word to transmit.
- tx_load  in  1  writes tx_data to the holding register when tx_ready=1.
- tx_ready  out  1  holding register empty.
- rx_data  out  FRAME_W-CH_BITS  received payload (frame[FRAME_W-1:CH_BITS]).
- rx_ch  out  CH_BITS  received channel ID (frame[CH_BITS-1:0]).
- rx_valid  out  1  rx_data/rx_ch valid; held until accepted.
- rx_ready  in  1  consumer accepts when rx_valid=1.
- overrun  out  1  sticky; a completed frame was dropped.
- ovr_clr  in  1  clears overrun.
- abort  out  1  one-cycle pulse; frame truncated by cs_bar rise.
- busy  out  1  frame in progress.

## Operation
- sclk, cs_bar and mosi each pass through SYNC_STAGES flops. The sclk and cs_bar edges are detected on the synchronised value.
- Leading edge: sclk transitions away from CPOL. Trailing edge: sclk transitions back to CPOL.
- CPHA=0: sample on the leading edge, shift on the trailing edge.
- CPHA=1: shift on the leading edge, sample on the trailing edge.
- FSM states: IDLE, SHIFT.
  - IDLE→SHIFT on the cs_bar falling edge. On entry:
    - The mode latch freezes.
    - The holding register is copied to the TX shift register, or zeros if tx_ready=1.
    - tx_ready is set to 1.
    - The bit counter is cleared.
    - miso presents the MSB immediately.
  - In SHIFT, each sample shifts mosi into the RX shift register (MSB first) and increments the counter.
  - When the counter reaches FRAME_W, the frame completes:
    - The counter wraps to 0.
    - The TX shift register reloads from the holding register, so back-to-back frames can run without toggling cs_bar.
    - The state stays SHIFT.
  - SHIFT→IDLE on the cs_bar rising edge. If the counter is in 1..FRAME_W-1, the partial frame is discarded and abort pulses. If the counter is 0, there is no abort.
- Completion with rx_valid=0 or (rx_valid & rx_ready) in the same cycle: the output register loads and rx_valid=1.
- Completion with rx_valid & !rx_ready: the new frame is dropped, the output is unchanged, and overrun is set.
- overrun and ovr_clr in the same cycle: overrun stays set.
- tx_load while tx_ready=0 is ignored. tx_load in the same cycle as a frame-start copy: the new word goes to the holding register for the next frame.
- Reset mid-frame returns to IDLE with no abort pulse.

## Timing
- Reset values:
  - miso=0, tx_ready=1, rx_valid=0, rx_data=0, rx_ch=0, overrun=0, abort=0, busy=0.
  - Mode latch = 0.
- Pin-to-internal-edge latency is SYNC_STAGES+1 clk cycles.
- rx_valid rises 1 clk after the final sampling edge is detected.
- miso changes 1 clk after a detected shift edge, or after the cs_bar fall.
- The sclk half-period must be ≥ SYNC_STAGES+3 clk cycles. With the default of 2 stages this is ≥ 5 clks, for example 50 MHz clk with sclk ≤ 5 MHz.
- busy = (state==SHIFT).

## Structure
- Package spi_pkg:
  - typedef enum spi_mode_e {SPI_MODE0..SPI_MODE3}.
  - typedef enum state_e {IDLE, SHIFT}.
  - Default constants for FRAME_W, CH_BITS and SYNC_STAGES.
- Sub-module spi_sync_edge: parametrised synchroniser plus rise/fall detect, instantiated for sclk and cs_bar. mosi uses the synchroniser output only.

## Test plan
- Mode 0, tx_data=16'hF1F1 loaded, MOSI frame 16'hABC3 → rx_ch=3, rx_data=12'hABC, rx_valid=1; MISO bit sequence = F1F1 MSB first.
- Modes 1, 2 and 3, frame 16'h5A5A each → rx_data=12'h5A5, rx_ch=4'hA in every mode.
- 16 back-to-back frames {12'd0,i} with cs_bar held low and rx_ready=1 → 16 rx_valid pulses, rx_ch=0..15, overrun=0.
- rx_ready=0, two frames → first frame held (rx_ch=0); second dropped, overrun=1. ovr_clr → overrun=0.
- cs_bar rises after 7 bits → abort pulse, rx_valid stays 0. Next full frame 16'h1234 → rx_ch=4, rx_data=12'h123.
- Reset asserted mid-frame (bit 9) → all outputs at reset values. After release, frame 16'h0001 → rx_ch=1, rx_data=0.
